// File: rtl/tx_module_pkg.sv
// Shared UART definitions: state encodings, parity modes and oversampling ratio.
package tx_module_pkg;

    // Oversampling ticks per bit period
    localparam int unsigned OVS = 16;

    // Parity-mode encodings for the PARITY parameter; 3 is treated as none
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Frame states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity bit over the low dbit bits of data; odd mode inverts the XOR
    function automatic logic frame_parity(input logic [7:0] data,
                                          input int unsigned dbit,
                                          input int unsigned mode);
        logic p;
        p = 1'b0;
        if (mode == PAR_NONE) begin
            return 1'b0;
        end
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < dbit) begin
                p = p ^ data[i];
            end
        end
        if (mode == PAR_ODD) begin
            p = ~p;
        end
        return p;
    endfunction

endpackage

// File: rtl/tx_module.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity, stop bit(s).
// Bit timing comes from an external 16x oversampling tick shared with the receiver.
module tx_module
    import tx_module_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned PARITY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic       s_tick,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam logic [4:0] OVS_LAST  = 5'(OVS - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam bit         PAR_EN    = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

    tx_state_e  state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_c;

    // Next-state, datapath and line-level decode from the current state
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        done_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    b_d     = din;
                    par_d   = frame_parity(din, DBIT, PARITY);
                    s_d     = 5'd0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == OVS_LAST) begin
                        s_d     = 5'd0;
                        n_d     = 3'd0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                tx_d = b_q[0];
                if (s_tick) begin
                    if (s_q == OVS_LAST) begin
                        s_d = 5'd0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_q;
                if (s_tick) begin
                    if (s_q == OVS_LAST) begin
                        s_d     = 5'd0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= 5'd0;
            n_q     <= 3'd0;
            b_q     <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_c;

endmodule

// File: tb/tb_tx_module.sv
// Bench for tx_module: four parameterisations, a line-decoding monitor with a
// frame scoreboard, plus directed timing checks against hand-computed values.
module tb_tx_module;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       par;
    } exp_t;

    // Per-instance configuration: DBIT, parity enabled, SB_TICK
    localparam int DB  [4] = '{8, 8, 8, 7};
    localparam int PE  [4] = '{0, 1, 1, 0};
    localparam int SBT [4] = '{16, 16, 16, 32};

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start [4];
    logic [7:0] din_a    [4];
    logic       tx_w     [4];
    logic       busy_w   [4];
    logic       done_w   [4];

    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_div = 1;
    int   tick_cnt = 0;
    int   sel = 0;
    int   m_frames = 0;
    exp_t exp_q [$];
    logic trace_q [0:2047];

    tx_module #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start[0]), .s_tick(s_tick), .din(din_a[0]),
        .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));
    tx_module #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start[1]), .s_tick(s_tick), .din(din_a[1]),
        .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));
    tx_module #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_dut2 (
        .clk(clk), .reset(reset), .tx_start(tx_start[2]), .s_tick(s_tick), .din(din_a[2]),
        .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));
    tx_module #(.DBIT(7), .SB_TICK(32), .PARITY(0)) u_dut3 (
        .clk(clk), .reset(reset), .tx_start(tx_start[3]), .s_tick(s_tick), .din(din_a[3]),
        .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversampling tick: high on every tick_div-th clock
    initial begin
        s_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            s_tick = ((tick_cnt % tick_div) == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: decode frames on the selected instance by counting ticks from the start edge
    initial begin : monitor
        bit         active;
        int         t;
        int         frame_ticks;
        int         idx;
        logic [7:0] m_data;
        logic       m_par;
        logic       start_ok;
        logic       stop_ok;
        exp_t       e;
        active = 0;
        t = 0;
        forever begin
            @(negedge clk);
            frame_ticks = 16 * (1 + DB[sel] + PE[sel]) + SBT[sel];
            if (reset === 1'b1) begin
                active = 0;
            end else if (!active) begin
                if (tx_w[sel] === 1'b0) begin
                    active   = 1;
                    t        = 0;
                    m_data   = 8'd0;
                    m_par    = 1'b0;
                    start_ok = 1'b1;
                    stop_ok  = 1'b1;
                end
            end else if (s_tick) begin
                t++;
                if ((t % 16) == 8 && t < 16 * (1 + DB[sel] + PE[sel])) begin
                    idx = t / 16;
                    if (idx == 0) begin
                        if (tx_w[sel] !== 1'b0) start_ok = 1'b0;
                    end else if (idx <= DB[sel]) begin
                        m_data[idx-1] = tx_w[sel];
                    end else begin
                        m_par = tx_w[sel];
                    end
                end
                if (t >= 16 * (1 + DB[sel] + PE[sel]) + 4 && tx_w[sel] !== 1'b1) begin
                    stop_ok = 1'b0;
                end
                if (t == frame_ticks - 2) begin
                    active = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got data 0x%0h expected no frame", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_inst", sel, e.inst);
                        chk("frame_data", {24'd0, m_data}, {24'd0, e.data});
                        if (PE[sel] != 0) chk("frame_parity", {31'd0, m_par}, {31'd0, e.par});
                        chk("frame_start_bit", {31'd0, start_ok}, 1);
                        chk("frame_stop_bits", {31'd0, stop_ok}, 1);
                        m_frames++;
                    end
                end
            end
        end
    end

    // Request a frame; returns just after the accept edge
    task automatic send_begin(input int idx, input logic [7:0] d, input logic [7:0] exp_d,
                              input logic exp_p, input bit hold);
        exp_t e;
        @(posedge clk);
        #1;
        din_a[idx]    = d;
        tx_start[idx] = 1'b1;
        e.inst = idx;
        e.data = exp_d;
        e.par  = exp_p;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) tx_start[idx] = 1'b0;
        chk("accept_tx_still_high", {31'd0, tx_w[idx]}, 1);
        chk("accept_busy", {31'd0, busy_w[idx]}, 1);
    endtask

    // Wait for tx_done_tick, recording the line each cycle; cyc=-1 on timeout
    task automatic wait_done(input int idx, input int bound, output int cyc, output int busy_low);
        cyc = -1;
        busy_low = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            trace_q[c] = tx_w[idx];
            if (busy_w[idx] !== 1'b1) busy_low++;
            if (done_w[idx] === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin : stim
        int         cyc;
        int         blow;
        int         cnt;
        logic [7:0] a5;
        logic [7:0] b8;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_start[i] = 1'b0;
            din_a[i]    = 8'd0;
        end

        // Reset held with tx_start asserted: outputs stay idle
        @(posedge clk);
        #1;
        tx_start[0] = 1'b1;
        din_a[0]    = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_tx", {31'd0, tx_w[0]}, 1);
            chk("reset_busy", {31'd0, busy_w[0]}, 0);
            chk("reset_done", {31'd0, done_w[0]}, 0);
        end
        @(posedge clk);
        #1;
        tx_start[0] = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy_w[i] !== 1'b0 || tx_w[i] !== 1'b1) cnt++;
        end
        chk("post_reset_idle", cnt, 0);

        // Default frame, din=0xA5
        sel = 0;
        send_begin(0, 8'hA5, 8'hA5, 1'b0, 1'b0);
        wait_done(0, 400, cyc, blow);
        chk("dflt_done_cycle", cyc, 159);
        chk("dflt_busy_low", blow, 0);
        cnt = 0;
        for (int c = 1; c <= 16; c++) if (trace_q[c] === 1'b0) cnt++;
        chk("dflt_start_low_clks", cnt, 16);
        a5 = 8'hA5;
        b8 = 8'd0;
        for (int k = 0; k < 8; k++) b8[k] = trace_q[25 + 16 * k];
        chk("dflt_bit_centres", {24'd0, b8}, {24'd0, a5});
        cnt = 0;
        for (int c = 145; c <= 159; c++) if (trace_q[c] === 1'b1) cnt++;
        chk("dflt_stop_high", cnt, 15);
        @(negedge clk);
        chk("dflt_done_single", {31'd0, done_w[0]}, 0);
        chk("dflt_busy_after", {31'd0, busy_w[0]}, 0);

        // Even parity, din=0x07 -> parity 1
        sel = 1;
        send_begin(1, 8'h07, 8'h07, 1'b1, 1'b0);
        wait_done(1, 400, cyc, blow);
        chk("even_done_cycle", cyc, 175);
        chk("even_parity_slot", {31'd0, trace_q[153]}, 1);
        send_begin(1, 8'h03, 8'h03, 1'b0, 1'b0);
        wait_done(1, 400, cyc, blow);
        chk("even2_done_cycle", cyc, 175);

        // Odd parity, din=0x07 -> parity 0
        sel = 2;
        send_begin(2, 8'h07, 8'h07, 1'b0, 1'b0);
        wait_done(2, 400, cyc, blow);
        chk("odd_done_cycle", cyc, 175);
        chk("odd_parity_slot", {31'd0, trace_q[153]}, 0);

        // DBIT=7, two stop bits, din=0xFF -> seven ones
        sel = 3;
        send_begin(3, 8'hFF, 8'h7F, 1'b0, 1'b0);
        wait_done(3, 400, cyc, blow);
        chk("d7_done_cycle", cyc, 159);
        chk("d7_busy_low", blow, 0);
        cnt = 0;
        for (int c = 129; c <= 159; c++) if (trace_q[c] === 1'b1) cnt++;
        chk("d7_stop_held", cnt, 31);

        // Slow tick; a tx_start pulse mid-data is ignored
        sel = 0;
        tick_div = 4;
        send_begin(0, 8'h3C, 8'h3C, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        tx_start[0] = 1'b1;
        din_a[0]    = 8'hFF;
        @(negedge clk);
        tx_start[0] = 1'b0;
        wait_done(0, 1000, cyc, blow);
        chk("slow_done_seen", {31'd0, cyc >= 0}, 1);
        chk("slow_busy_low", blow, 0);

        // tx_start held through done: next frame starts after one idle cycle
        send_begin(0, 8'h5A, 8'h5A, 1'b0, 1'b1);
        din_a[0] = 8'hC3;
        wait_done(0, 1000, cyc, blow);
        chk("held_done_seen", {31'd0, cyc >= 0}, 1);
        begin
            exp_t e;
            e.inst = 0;
            e.data = 8'hC3;
            e.par  = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("held_idle_busy", {31'd0, busy_w[0]}, 0);
        chk("held_idle_tx", {31'd0, tx_w[0]}, 1);
        @(posedge clk);
        #1;
        tx_start[0] = 1'b0;
        chk("held_accept_busy", {31'd0, busy_w[0]}, 1);
        chk("held_accept_tx", {31'd0, tx_w[0]}, 1);
        @(posedge clk);
        #1;
        chk("held_start_tx", {31'd0, tx_w[0]}, 0);
        wait_done(0, 1000, cyc, blow);
        chk("held2_done_seen", {31'd0, cyc >= 0}, 1);
        @(negedge clk);

        // Reset mid-data aborts; next frame is complete
        tick_div = 1;
        @(posedge clk);
        #1;
        din_a[0]    = 8'h96;
        tx_start[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_start[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_tx", {31'd0, tx_w[0]}, 1);
        chk("abort_busy", {31'd0, busy_w[0]}, 0);
        chk("abort_done", {31'd0, done_w[0]}, 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        send_begin(0, 8'h69, 8'h69, 1'b0, 1'b0);
        wait_done(0, 400, cyc, blow);
        chk("after_abort_done_cycle", cyc, 159);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("frames_decoded", m_frames, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
